// File: rtl/rom_byte_loader_if.sv
// Byte-stream in / word-write out bundle for rom_byte_loader.
// master = loader side, slave = source/memory side.
interface rom_byte_loader_if #(
  parameter int ADR_W = 8
);
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             wr_en;
  logic [ADR_W-1:0] wr_adr;
  logic [31:0]      wr_data;

  modport master (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_adr, wr_data
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_adr, wr_data
  );
endinterface

// File: rtl/rom_byte_loader.sv
// Packs a byte stream little-endian into 32-bit words and writes them
// to consecutive word addresses. ROM_LOADER_CHECKSUM_EN adds `checksum`.
module rom_byte_loader #(
  parameter int ADR_W    = 8,
  parameter int LAST_ADR = 2**ADR_W - 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  rom_byte_loader_if.master bus,
  output logic busy,
  output logic done
`ifdef ROM_LOADER_CHECKSUM_EN
  ,
  output logic [7:0] checksum
`endif
);

  localparam logic [ADR_W-1:0] LAST = ADR_W'(LAST_ADR);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WRITE,
    DONE
  } state_t;

  state_t           state;
  logic [ADR_W-1:0] adr;
  logic [1:0]       lane;
  logic [31:0]      asm_q;
  logic             rdy_q;
  logic             wr_en_q;
  logic [ADR_W-1:0] wr_adr_q;
  logic [31:0]      wr_data_q;
  logic             accept;
  logic             go;

  assign accept = bus.in_valid & rdy_q;
  assign go     = start & ((state == IDLE) | (state == DONE));

  assign bus.in_ready = rdy_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_adr   = wr_adr_q;
  assign bus.wr_data  = wr_data_q;

  // Loader FSM: collect four lanes, emit one write, stop after LAST.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      adr       <= '0;
      lane      <= '0;
      asm_q     <= '0;
      rdy_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_adr_q  <= '0;
      wr_data_q <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= LOAD;
            adr   <= '0;
            lane  <= '0;
            asm_q <= '0;
            rdy_q <= 1'b1;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            asm_q[{lane, 3'b000} +: 8] <= bus.in_data;
            lane <= lane + 2'd1;
            if (lane == 2'd3) begin
              state     <= WRITE;
              rdy_q     <= 1'b0;
              wr_en_q   <= 1'b1;
              wr_adr_q  <= adr;
              wr_data_q <= {bus.in_data, asm_q[23:0]};
            end
          end
        end
        WRITE: begin
          wr_en_q <= 1'b0;
          if (adr == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= LOAD;
            adr   <= adr + 1'b1;
            lane  <= '0;
            rdy_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ROM_LOADER_CHECKSUM_EN
  // Running mod-256 sum of accepted bytes, restarted by each load.
  always_ff @(posedge clk) begin
    if (rst || go) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= checksum + bus.in_data;
    end
  end
`else
  logic unused_go;
  assign unused_go = go;
`endif

endmodule

// File: tb/tb_rom_byte_loader.sv
// Scoreboard bench for rom_byte_loader: expected writes are queued as
// bytes are handed over and retired when wr_en is seen.
module tb_rom_byte_loader;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic busy;
  logic done;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  rom_byte_loader_if #(.ADR_W(8)) bus ();

  rom_byte_loader #(.ADR_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus),
    .busy     (busy),
    .done     (done)
`ifdef ROM_LOADER_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_wr    = 0;
  int tick    = 0;
  int m_adr   = 0;
  int m_lane  = 0;
  logic [31:0] m_word = '0;
  logic [7:0]  csum   = '0;
  logic [39:0] sb_q[$];

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Retire one expected write per observed strobe.
  always @(negedge clk) begin
    if (!rst && bus.wr_en) begin
      logic [39:0] e;
      n_wr++;
      check("wr_expected", 64'(sb_q.size() > 0), 64'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("wr_adr", 64'(bus.wr_adr), 64'(e[39:32]));
        check("wr_data", 64'(bus.wr_data), 64'(e[31:0]));
        check("rdy_in_write", 64'(bus.in_ready), 64'd0);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t;
    bit ok;
    t = 0;
    ok = 1'b0;
    while (!ok && t < 40) begin
      @(negedge clk);
      bus.in_valid = gap ? (tick % 3 == 0) : 1'b1;
      bus.in_data  = b;
      tick++;
      ok = bus.in_valid && bus.in_ready;
      t++;
    end
    if (!ok) begin
      check("accept_timeout", 64'd0, 64'd1);
    end else begin
      m_word[8*m_lane +: 8] = b;
      csum = csum + b;
      m_lane++;
      if (m_lane == 4) begin
        sb_q.push_back({m_adr[7:0], m_word});
        m_adr++;
        m_lane = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic pulse_start(input bit fresh);
    @(negedge clk);
    bus.in_valid = 1'b0;
    start = 1'b1;
    if (fresh) begin
      m_adr  = 0;
      m_lane = 0;
      m_word = '0;
      csum   = '0;
      n_wr   = 0;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    @(negedge clk);
    rst = 1'b0;
    m_adr  = 0;
    m_lane = 0;
    m_word = '0;
    csum   = '0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!done && t < 100) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      t++;
    end
    check("done_seen", 64'(done), 64'd1);
  endtask

  task automatic full_load(input bit ones);
    for (int n = 0; n < 1024; n++) begin
      if (!ones && n == 42) begin
        pulse_start(1'b0);
        check("busy_kept", 64'(busy), 64'd1);
      end
      send_byte(ones ? 8'h01 : 8'(n), n >= 8 && n < 16);
    end
    wait_done();
    check("busy_done", 64'(busy), 64'd0);
    check("rdy_done", 64'(bus.in_ready), 64'd0);
    check("wr_count", 64'(n_wr), 64'd256);
    check("sb_drained", 64'(sb_q.size()), 64'd0);
`ifdef ROM_LOADER_CHECKSUM_EN
    check("csum_model", 64'(checksum), 64'(csum));
    check("csum_zero", 64'(checksum), 64'd0);
`endif
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    do_reset();
    check("rst_ready", 64'(bus.in_ready), 64'd0);
    check("rst_wr_en", 64'(bus.wr_en), 64'd0);
    check("rst_wr_adr", 64'(bus.wr_adr), 64'd0);
    check("rst_wr_data", 64'(bus.wr_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);

    // single word, then reset right after it
    pulse_start(1'b1);
    check("start_busy", 64'(busy), 64'd1);
    check("start_ready", 64'(bus.in_ready), 64'd1);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    check("wr_before", 64'(bus.wr_en), 64'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("wr_after4", 64'(bus.wr_en), 64'd1);
    check("wr_word0", 64'(bus.wr_data), 64'h44332211);
    idle(2);
    do_reset();
    check("sb_after_a", 64'(sb_q.size()), 64'd0);

    // full ramp load with gaps and an ignored start at word 10
    pulse_start(1'b1);
    full_load(1'b0);

    // bytes offered in DONE are dropped
    repeat (3) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h5a;
      check("rdy_in_done", 64'(bus.in_ready), 64'd0);
    end
    idle(2);
    check("done_hold", 64'(done), 64'd1);
`ifdef ROM_LOADER_CHECKSUM_EN
    check("csum_hold", 64'(checksum), 64'd0);
`endif

    // restart from DONE, abort with reset inside word 5
    pulse_start(1'b1);
    check("restart_done", 64'(done), 64'd0);
    check("restart_busy", 64'(busy), 64'd1);
    for (int n = 0; n < 22; n++) send_byte(8'(n * 7), 1'b0);
    idle(1);
    do_reset();
    check("rst_mid_wr_en", 64'(bus.wr_en), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_wr_cnt", 64'(n_wr), 64'd5);
    idle(3);
    pulse_start(1'b1);
    send_byte(8'ha0, 1'b0);
    send_byte(8'ha1, 1'b1);
    send_byte(8'ha2, 1'b1);
    send_byte(8'ha3, 1'b0);
    idle(3);
    check("first_after_rst", 64'(n_wr), 64'd1);
    check("sb_after_c", 64'(sb_q.size()), 64'd0);

    // all-ones load
    do_reset();
    pulse_start(1'b1);
    full_load(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
